// File: rtl/pc_ctrl.sv
// pc_ctrl: program counter controller with BOOT/RUN/HALT sequencing.
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   rst        - synchronous active-low reset
//   pause      - stall request, holds PC in RUN
//   flush      - redirect request, loads NPC (or traps if NPC misaligned)
//   NPC        - redirect target
//   trap       - exception request, saves PC to epc and vectors to TRAP_VEC
//   mret       - trap return, loads epc into PC
//   halt       - request to enter HALT
//   resume     - request to leave HALT
//   imem_ready - instruction memory accepted the current fetch address
//   PC         - current fetch address (registered)
//   if_valid   - PC is a valid fetch request (RUN only)
//   epc        - saved exception PC (registered)
//   misalign   - one-cycle pulse after a misaligned redirect
//   state      - BOOT=0, RUN=1, HALT=2
//
// state | meaning
// ------+--------------------------------------------------------------
// BOOT  | single cycle after reset, inputs ignored, then RUN
// RUN   | fetching; trap > mret > flush > halt > hold > advance
// HALT  | PC held; trap returns to RUN, flush redirects, resume -> RUN
module pc_ctrl #(
    parameter int                 WIDTH     = 32,
    parameter int                 INC       = 4,
    parameter logic [WIDTH-1:0]   RESET_VEC = WIDTH'(32'h0000_0000),
    parameter logic [WIDTH-1:0]   TRAP_VEC  = WIDTH'(32'h0000_0100)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pause,
    input  logic              flush,
    input  logic [WIDTH-1:0]  NPC,
    input  logic              trap,
    input  logic              mret,
    input  logic              halt,
    input  logic              resume,
    input  logic              imem_ready,
    output logic [WIDTH-1:0]  PC,
    output logic              if_valid,
    output logic [WIDTH-1:0]  epc,
    output logic              misalign,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    // Low log2(INC) address bits; any set bit means the target is misaligned.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);
    localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  pc_q, pc_d;
    logic [WIDTH-1:0]  epc_q, epc_d;
    logic              misalign_q, misalign_d;
    logic              npc_bad;

    assign npc_bad = (NPC & ALIGN_MASK) != '0;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        misalign_d = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (trap) begin
                    epc_d = pc_q;
                    pc_d  = TRAP_VEC;
                end else if (mret) begin
                    pc_d = epc_q;
                end else if (flush) begin
                    if (npc_bad) begin
                        epc_d      = NPC;
                        pc_d       = TRAP_VEC;
                        misalign_d = 1'b1;
                    end else begin
                        pc_d = NPC;
                    end
                end else if (halt) begin
                    state_d = HALT;
                end else if (!pause && imem_ready) begin
                    pc_d = pc_q + INC_W;
                end
            end
            HALT: begin
                if (trap) begin
                    epc_d   = pc_q;
                    pc_d    = TRAP_VEC;
                    state_d = RUN;
                end else if (flush) begin
                    // Redirect while halted; the block stays halted.
                    if (npc_bad) begin
                        epc_d      = NPC;
                        pc_d       = TRAP_VEC;
                        misalign_d = 1'b1;
                    end else begin
                        pc_d = NPC;
                    end
                end else if (resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            epc_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            misalign_q <= misalign_d;
        end
    end

    assign PC       = pc_q;
    assign epc      = epc_q;
    assign misalign = misalign_q;
    assign state    = state_q;
    assign if_valid = (state_q == RUN);

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed-vector bench for pc_ctrl, default 32-bit build plus an
// 8-bit build for wraparound and reset-in-HALT.
module tb_pc_ctrl;

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic        clk;
    logic        rst, pause, flush, trap, mret, halt, resume, imem_ready;
    logic [31:0] npc;
    logic [31:0] pc, epc;
    logic        if_valid, misalign;
    logic [1:0]  state;

    logic        rst8, flush8, trap8, halt8, resume8;
    logic [7:0]  npc8;
    logic [7:0]  pc8, epc8;
    logic        if_valid8, misalign8;
    logic [1:0]  state8;

    int checks = 0;
    int errors = 0;

    pc_ctrl dut (
        .clk(clk), .rst(rst), .pause(pause), .flush(flush), .NPC(npc),
        .trap(trap), .mret(mret), .halt(halt), .resume(resume),
        .imem_ready(imem_ready), .PC(pc), .if_valid(if_valid), .epc(epc),
        .misalign(misalign), .state(state)
    );

    pc_ctrl #(
        .WIDTH(8), .INC(4), .RESET_VEC(8'h10), .TRAP_VEC(8'h80)
    ) dut8 (
        .clk(clk), .rst(rst8), .pause(1'b0), .flush(flush8), .NPC(npc8),
        .trap(trap8), .mret(1'b0), .halt(halt8), .resume(resume8),
        .imem_ready(1'b1), .PC(pc8), .if_valid(if_valid8), .epc(epc8),
        .misalign(misalign8), .state(state8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Checks all observable outputs of the 32-bit instance; if_valid follows state.
    task automatic expect_main(input string tag, input logic [31:0] e_pc,
                               input logic [31:0] e_epc, input logic [1:0] e_st,
                               input logic e_mis);
        chk({tag, ".pc"},       pc,                 e_pc);
        chk({tag, ".epc"},      epc,                e_epc);
        chk({tag, ".state"},    {30'd0, state},     {30'd0, e_st});
        chk({tag, ".if_valid"}, {31'd0, if_valid},  {31'd0, (e_st == S_RUN)});
        chk({tag, ".misalign"}, {31'd0, misalign},  {31'd0, e_mis});
    endtask

    task automatic expect_8(input string tag, input logic [7:0] e_pc,
                            input logic [7:0] e_epc, input logic [1:0] e_st);
        chk({tag, ".pc"},       {24'd0, pc8},        {24'd0, e_pc});
        chk({tag, ".epc"},      {24'd0, epc8},       {24'd0, e_epc});
        chk({tag, ".state"},    {30'd0, state8},     {30'd0, e_st});
        chk({tag, ".if_valid"}, {31'd0, if_valid8},  {31'd0, (e_st == S_RUN)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; pause = 1'b0; flush = 1'b0; trap = 1'b0; mret = 1'b0;
        halt = 1'b0; resume = 1'b0; imem_ready = 1'b1; npc = 32'h0;
        rst8 = 1'b0; flush8 = 1'b0; trap8 = 1'b0; halt8 = 1'b0; resume8 = 1'b0;
        npc8 = 8'h0;

        // Reset with requests pending: all must be discarded.
        trap = 1'b1; flush = 1'b1; npc = 32'h40;
        step(); step();
        trap = 1'b0; flush = 1'b0;
        expect_main("reset", 32'h0, 32'h0, S_BOOT, 1'b0);

        // Release: one BOOT cycle, then sequential fetch 0,4,8.
        rst = 1'b1;
        expect_main("boot", 32'h0, 32'h0, S_BOOT, 1'b0);
        step(); expect_main("run0", 32'h0, 32'h0, S_RUN, 1'b0);
        step(); expect_main("run4", 32'h4, 32'h0, S_RUN, 1'b0);
        step(); expect_main("run8", 32'h8, 32'h0, S_RUN, 1'b0);

        // Halt at 0x8, sit there five cycles ignoring mret/pause/imem_ready.
        halt = 1'b1;
        step(); expect_main("halt_enter", 32'h8, 32'h0, S_HALT, 1'b0);
        halt = 1'b0; mret = 1'b1; pause = 1'b1; imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(); expect_main($sformatf("halt_hold%0d", i), 32'h8, 32'h0, S_HALT, 1'b0);
        end
        mret = 1'b0; pause = 1'b0; imem_ready = 1'b1;
        halt = 1'b1; resume = 1'b1;
        step(); expect_main("resume", 32'h8, 32'h0, S_RUN, 1'b0);
        halt = 1'b0; resume = 1'b1;
        step(); expect_main("resume_ign", 32'hC, 32'h0, S_RUN, 1'b0);
        resume = 1'b0;
        step(); expect_main("run10", 32'h10, 32'h0, S_RUN, 1'b0);

        // Flush beats pause; pause and imem_ready=0 hold.
        pause = 1'b1; flush = 1'b1; npc = 32'h40;
        step(); expect_main("flush_pause", 32'h40, 32'h0, S_RUN, 1'b0);
        flush = 1'b0;
        step(); expect_main("pause", 32'h40, 32'h0, S_RUN, 1'b0);
        pause = 1'b0; imem_ready = 1'b0;
        step(); expect_main("not_ready", 32'h40, 32'h0, S_RUN, 1'b0);
        imem_ready = 1'b1;
        step(); expect_main("run44", 32'h44, 32'h0, S_RUN, 1'b0);

        // Trap beats flush; mret beats halt.
        flush = 1'b1; npc = 32'h20;
        step(); expect_main("flush20", 32'h20, 32'h0, S_RUN, 1'b0);
        trap = 1'b1; npc = 32'h80;
        step(); expect_main("trap", 32'h100, 32'h20, S_RUN, 1'b0);
        trap = 1'b0; flush = 1'b0;
        step(); expect_main("trap_seq", 32'h104, 32'h20, S_RUN, 1'b0);
        mret = 1'b1; halt = 1'b1;
        step(); expect_main("mret", 32'h20, 32'h20, S_RUN, 1'b0);
        mret = 1'b0; halt = 1'b0;
        step(); expect_main("mret_seq", 32'h24, 32'h20, S_RUN, 1'b0);

        // Misaligned redirect: trap vector, epc = target, one-cycle pulse.
        flush = 1'b1; npc = 32'h42;
        step(); expect_main("misalign", 32'h100, 32'h42, S_RUN, 1'b1);
        flush = 1'b0;
        step(); expect_main("misalign_end", 32'h104, 32'h42, S_RUN, 1'b0);

        // Redirect while halted stays halted; trap leaves HALT.
        halt = 1'b1;
        step(); expect_main("halt2", 32'h104, 32'h42, S_HALT, 1'b0);
        halt = 1'b0; flush = 1'b1; npc = 32'h200;
        step(); expect_main("halt_flush", 32'h200, 32'h42, S_HALT, 1'b0);
        flush = 1'b0; trap = 1'b1;
        step(); expect_main("halt_trap", 32'h100, 32'h200, S_RUN, 1'b0);
        trap = 1'b0;
        step(); expect_main("halt_trap_seq", 32'h104, 32'h200, S_RUN, 1'b0);

        // Mid-operation reset with requests pending.
        trap = 1'b1; flush = 1'b1; npc = 32'h42; halt = 1'b1; rst = 1'b0;
        step(); expect_main("mid_reset", 32'h0, 32'h0, S_BOOT, 1'b0);
        trap = 1'b0; flush = 1'b0; halt = 1'b0; rst = 1'b1;
        step(); expect_main("mid_reset_run", 32'h0, 32'h0, S_RUN, 1'b0);

        // 8-bit build: wraparound and reset while halted.
        expect_8("w8_reset", 8'h10, 8'h00, S_BOOT);
        rst8 = 1'b1;
        step(); expect_8("w8_run", 8'h10, 8'h00, S_RUN);
        flush8 = 1'b1; npc8 = 8'hFC;
        step(); expect_8("w8_fc", 8'hFC, 8'h00, S_RUN);
        flush8 = 1'b0;
        step(); expect_8("w8_wrap", 8'h00, 8'h00, S_RUN);
        step(); expect_8("w8_04", 8'h04, 8'h00, S_RUN);
        trap8 = 1'b1;
        step(); expect_8("w8_trap", 8'h80, 8'h04, S_RUN);
        trap8 = 1'b0; halt8 = 1'b1;
        step(); expect_8("w8_halt", 8'h80, 8'h04, S_HALT);
        halt8 = 1'b0; resume8 = 1'b1; rst8 = 1'b0;
        step(); expect_8("w8_halt_reset", 8'h10, 8'h00, S_BOOT);
        chk("w8_misalign", {31'd0, misalign8}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, PC/address width in bits.
REQ-002 Parameter INC, default 4, sequential increment in bytes; power of two; ALIGN = log2(INC).
REQ-003 Parameter RESET_VEC, default 32'h0000_0000, PC value loaded by reset.
REQ-004 Parameter TRAP_VEC, default 32'h0000_0100, PC value loaded on trap or misaligned redirect.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-low reset; rst=0 at a rising edge resets the block.
REQ-007 pause  in  1  pipeline stall request; holds PC.
REQ-008 flush  in  1  redirect request (branch/jump taken); loads NPC.
REQ-009 NPC  in  WIDTH  redirect target, sampled when flush wins arbitration.
REQ-010 trap  in  1  exception request; saves PC to epc, vectors to TRAP_VEC.
REQ-011 mret  in  1  trap return; loads epc into PC.
REQ-012 halt  in  1  request to enter HALT state.
REQ-013 resume  in  1  request to leave HALT state.
REQ-014 imem_ready  in  1  instruction memory accepted the current fetch address.
REQ-015 PC  out  WIDTH  current fetch address, registered.
REQ-016 if_valid  out  1  PC is a valid fetch request this cycle.
REQ-017 epc  out  WIDTH  saved exception PC, registered.
REQ-018 misalign  out  1  one-cycle pulse: last redirect target was misaligned.
REQ-019 state  out  2  BOOT=2'd0, RUN=2'd1, HALT=2'd2; 2'd3 unused.

Function
REQ-020 States BOOT, RUN, HALT; BOOT lasts exactly one cycle, then RUN unconditionally; all inputs ignored in BOOT.
REQ-021 if_valid = 1 only in RUN; 0 in BOOT and HALT (combinational from state).
REQ-022 RUN per-cycle priority, highest first: trap > mret > flush > halt > hold (pause=1 or imem_ready=0) > sequential advance.
REQ-023 trap in RUN: epc <= PC, PC <= TRAP_VEC, stay RUN.
REQ-024 mret in RUN: PC <= epc, epc unchanged.
REQ-025 flush in RUN, NPC[ALIGN-1:0]==0: PC <= NPC; flush overrides pause and imem_ready=0.
REQ-026 flush in RUN, NPC[ALIGN-1:0]!=0: epc <= NPC, PC <= TRAP_VEC, misalign=1 next cycle only.
REQ-027 halt in RUN (no higher request): PC held, state <= HALT.
REQ-028 Hold: PC, epc unchanged.
REQ-029 Sequential: PC <= PC + INC, truncated to WIDTH bits (wraps all-ones region to low addresses, no flag).
REQ-030 HALT: PC held; trap -> epc <= PC, PC <= TRAP_VEC, state <= RUN; else flush -> REQ-025/026 rules, stay HALT; else resume -> state <= RUN, PC unchanged; mret, pause, imem_ready ignored.
REQ-031 halt and resume both 1 in HALT: resume wins; in RUN resume is ignored.
REQ-032 misalign is 0 in every cycle not immediately following a REQ-026 event.
REQ-033 Latency: every PC/epc/state update visible one cycle after the sampling edge.

Reset
REQ-034 rst=0 at a rising edge: PC <= RESET_VEC, epc <= 0, misalign <= 0, state <= BOOT, overriding all other inputs in that cycle.
REQ-035 Reset asserted mid-operation (RUN or HALT, any request pending) takes effect at that edge; pending requests are discarded.
REQ-036 After rst returns to 1: one BOOT cycle (if_valid=0, PC=RESET_VEC), then RUN fetching RESET_VEC.

Verification
REQ-037 Reset release, pause=0, imem_ready=1 -> PC sequence 0x0 (BOOT, if_valid=0), 0x0, 0x4, 0x8, 0xC with if_valid=1.
REQ-038 In RUN at PC=0x10: pause=1 and flush=1 NPC=0x40 same cycle -> PC=0x40 next; pause=1 alone -> PC stays 0x40; imem_ready=0 -> PC stays.
REQ-039 PC=0x20, trap=1 and flush=1 -> epc=0x20, PC=0x100; later mret=1 -> PC=0x20.
REQ-040 flush=1 NPC=0x42 -> PC=0x100, epc=0x42, misalign=1 for exactly one cycle.
REQ-041 halt=1 at PC=0x8 -> state=HALT, if_valid=0, PC=0x8 for 5 cycles; resume=1 -> RUN, PC=0x8 then 0xC.
REQ-042 WIDTH=8 build, PC=0xFC sequential -> PC=0x00; rst=0 while in HALT -> PC=RESET_VEC, epc=0, state=BOOT next cycle.
